// File: rtl/mmio_irq_responder_if.sv
// mmio_irq_responder_if: CPU memory-bus bundle between the controller and the MMIO responder.
//   mem_cmd    2   2'b10 read, 2'b01 write, others idle (master drives)
//   mem_addr   9   word address (master drives)
//   write_data 16  store data (master drives)
//   read_data  16  registered read data, 0 when the window is not hit (slave drives)
//   read_hit   1   read_data carries window data this cycle (slave drives)
interface mmio_irq_responder_if;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          read_hit;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  read_hit
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output read_hit
    );
endinterface

// File: rtl/mmio_irq_responder.sv
// mmio_irq_responder: MMIO register window (switches, LEDs, down-counting timer,
// interrupt status) on the CPU memory bus, plus the single-cycle isr pulse source.
// read_data is zero whenever the window is not addressed so it can be ORed with RAM.
//
// Optional feature macro: MMIO_EXT_IRQ_EN
//   defined   : ext_irq is double-flop synchronized; its rising edge sets xpend.
//   undefined : ext_irq is ignored, xpend reads 0, no synchronizer is built.
//
// Ports
//   i_clk      in   1   system clock
//   i_reset    in   1   synchronous, active-high reset
//   bus        slave    mem_cmd / mem_addr / write_data in, read_data / read_hit out
//   i_sw       in   8   board switches
//   i_ext_irq  in   1   external interrupt line
//   o_leds     out  8   LED register
//   o_isr      out  1   one-cycle interrupt pulse (decoded from FSM state)
//
// Register map (word offset from BASE)
//   0 SW RO | 1 LED RW[7:0] | 2 TLOAD RW | 3 TCOUNT RO | 4 CTRL {reload,irq_en,ten}
//   5 STATUS {xpend,tpend} W1C | 6,7 read 0
module mmio_irq_responder #(
    parameter logic [8:0]  BASE     = 9'h140,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    mmio_irq_responder_if.slave    bus,
    input  logic [7:0]             i_sw,
    input  logic                   i_ext_irq,
    output logic [7:0]             o_leds,
    output logic                   o_isr
);
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 8;

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    localparam logic [2:0] OFF_SW     = 3'd0;
    localparam logic [2:0] OFF_LED    = 3'd1;
    localparam logic [2:0] OFF_TLOAD  = 3'd2;
    localparam logic [2:0] OFF_TCOUNT = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FIRE    = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    // Register state
    logic [DW-1:0] r_read_data;
    logic          r_read_hit;
    logic [7:0]    r_leds;
    logic [DW-1:0] r_tload;
    logic [DW-1:0] r_tcount;
    logic          r_ten;
    logic          r_irq_en;
    logic          r_reload;
    logic          r_tpend;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_state;

    // Decode
    logic          w_hit;
    logic [2:0]    w_off;
    logic          w_rd;
    logic          w_wr;
    logic          w_wr_led;
    logic          w_wr_tload;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic [DW-1:0] w_rdata;
    logic          w_tick;
    logic          w_dec;
    logic          w_expire;
    logic          w_xpend;
    logic          w_pend;
    logic [1:0]    w_state_nxt;

    // Address window decode
    always_comb begin
        w_hit       = (bus.mem_addr[8:3] == BASE[8:3]);
        w_off       = bus.mem_addr[2:0];
        w_rd        = (bus.mem_cmd == CMD_READ)  && w_hit;
        w_wr        = (bus.mem_cmd == CMD_WRITE) && w_hit;
        w_wr_led    = w_wr && (w_off == OFF_LED);
        w_wr_tload  = w_wr && (w_off == OFF_TLOAD);
        w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
        w_wr_status = w_wr && (w_off == OFF_STATUS);
    end

    // Read mux: values as they stand before this edge's updates
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_SW:     w_rdata = {8'b0, i_sw};
            OFF_LED:    w_rdata = {8'b0, r_leds};
            OFF_TLOAD:  w_rdata = r_tload;
            OFF_TCOUNT: w_rdata = r_tcount;
            OFF_CTRL:   w_rdata = {13'b0, r_reload, r_irq_en, r_ten};
            OFF_STATUS: w_rdata = {14'b0, w_xpend, r_tpend};
            default:    w_rdata = '0;
        endcase
    end

    // Registered read port
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_data <= '0;
            r_read_hit  <= 1'b0;
        end else if (w_rd) begin
            r_read_data <= w_rdata;
            r_read_hit  <= 1'b1;
        end else begin
            r_read_data <= '0;
            r_read_hit  <= 1'b0;
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.read_hit  = r_read_hit;

    // LED and CTRL registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_leds   <= '0;
            r_ten    <= 1'b0;
            r_irq_en <= 1'b0;
            r_reload <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_leds <= bus.write_data[7:0];
            end
            if (w_wr_ctrl) begin
                r_ten    <= bus.write_data[0];
                r_irq_en <= bus.write_data[1];
                r_reload <= bus.write_data[2];
            end
        end
    end

    assign o_leds = r_leds;

    // Prescaler: free-runs only while the timer is enabled, restarts when disabled
    always_comb begin
        w_tick   = r_ten && (r_presc == PRESC_LAST);
        w_dec    = w_tick && (r_tcount != '0);
        w_expire = w_dec && (r_tcount == DW'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
        end else if (!r_ten || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Timer: a TLOAD write overrides the decrement/reload on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tload  <= '0;
            r_tcount <= '0;
        end else if (w_wr_tload) begin
            r_tload  <= bus.write_data;
            r_tcount <= bus.write_data;
        end else if (w_expire) begin
            r_tcount <= r_reload ? r_tload : '0;
        end else if (w_dec) begin
            r_tcount <= r_tcount - DW'(1);
        end
    end

    // tpend: hardware set wins over a same-cycle W1C
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tpend <= 1'b0;
        end else begin
            r_tpend <= (r_tpend & ~(w_wr_status & bus.write_data[0])) | w_expire;
        end
    end

`ifdef MMIO_EXT_IRQ_EN
    // Two-flop synchronizer plus one history flop for rising-edge detect
    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;
    logic r_xpend;
    logic w_xrise;

    assign w_xrise = r_sync2 & ~r_sync_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_xpend     <= 1'b0;
        end else begin
            r_sync1     <= i_ext_irq;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_xpend     <= (r_xpend & ~(w_wr_status & bus.write_data[1])) | w_xrise;
        end
    end

    assign w_xpend = r_xpend;
`else
    logic w_unused_ext_irq;
    assign w_unused_ext_irq = i_ext_irq;
    assign w_xpend          = 1'b0;
`endif

    assign w_pend = r_tpend | w_xpend;

    // IRQ FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IRQ FSM next state: one FIRE cycle per episode, SERVICE blocks re-pulsing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_irq_en && w_pend) begin
                    w_state_nxt = S_FIRE;
                end
            end
            S_FIRE: begin
                w_state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (!w_pend || !r_irq_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_isr = (r_state == S_FIRE);

endmodule

// File: tb/tb_mmio_irq_responder.sv
// Directed self-checking bench for mmio_irq_responder (BASE=9'h140, PRESCALE=1).
module tb_mmio_irq_responder;
    localparam logic [8:0] A_SW     = 9'h140;
    localparam logic [8:0] A_LED    = 9'h141;
    localparam logic [8:0] A_TLOAD  = 9'h142;
    localparam logic [8:0] A_TCOUNT = 9'h143;
    localparam logic [8:0] A_CTRL   = 9'h144;
    localparam logic [8:0] A_STATUS = 9'h145;
    localparam logic [8:0] A_RSV6   = 9'h146;
    localparam logic [8:0] A_RSV7   = 9'h147;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       ext_irq;
    logic [7:0] leds;
    logic       isr;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_irq_responder_if bus ();

    mmio_irq_responder #(.BASE(9'h140), .PRESCALE(1)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .bus       (bus.slave),
        .i_sw      (sw),
        .i_ext_irq (ext_irq),
        .o_leds    (leds),
        .o_isr     (isr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = 2'b01;
        bus.mem_addr   = a;
        bus.write_data = d;
        tick();
        bus.mem_cmd    = 2'b00;
    endtask

    task automatic do_read(input logic [8:0] a, output logic [15:0] d, output logic h);
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = a;
        tick();
        d = bus.read_data;
        h = bus.read_hit;
        bus.mem_cmd = 2'b00;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        sw             = 8'h00;
        ext_irq        = 1'b0;
        bus.mem_cmd    = 2'b00;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        tick();
        tick();
        reset = 1'b0;
        n_tests++; if (bus.read_data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0000", bus.read_data); end
        n_tests++; if (bus.read_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b exp 0", bus.read_hit); end
        n_tests++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds got %h exp 00", leds); end
        n_tests++; if (isr !== 1'b0) begin n_fail++; $display("FAIL reset_isr got %b exp 0", isr); end
    endtask

    task automatic test_read();
        sw           = 8'hA5;
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = A_SW;
        tick();
        n_tests++; if (bus.read_data !== 16'h00A5) begin n_fail++; $display("FAIL read_sw got %h exp 00a5", bus.read_data); end
        n_tests++; if (bus.read_hit !== 1'b1) begin n_fail++; $display("FAIL read_sw_hit got %b exp 1", bus.read_hit); end
        tick();
        n_tests++; if (bus.read_data !== 16'h00A5) begin n_fail++; $display("FAIL read_hold got %h exp 00a5", bus.read_data); end
        bus.mem_addr = 9'h020;
        tick();
        n_tests++; if (bus.read_data !== 16'h0) begin n_fail++; $display("FAIL read_miss got %h exp 0000", bus.read_data); end
        n_tests++; if (bus.read_hit !== 1'b0) begin n_fail++; $display("FAIL read_miss_hit got %b exp 0", bus.read_hit); end
        bus.mem_cmd  = 2'b00;
        bus.mem_addr = A_SW;
        tick();
        n_tests++; if (bus.read_hit !== 1'b0) begin n_fail++; $display("FAIL idle_hit got %b exp 0", bus.read_hit); end
    endtask

    task automatic test_led();
        logic [15:0] d;
        logic        h;
        do_write(A_LED, 16'h12FF);
        n_tests++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL led_out got %h exp ff", leds); end
        do_read(A_LED, d, h);
        n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL led_rb got %h exp 00ff", d); end
        do_write(A_RSV6, 16'h0000);
        do_read(A_RSV6, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rsv6_rd got %h exp 0000", d); end
        n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL rsv6_hit got %b exp 1", h); end
        n_tests++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL rsv6_leds got %h exp ff", leds); end
        do_read(A_RSV7, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rsv7_rd got %h exp 0000", d); end
    endtask

    task automatic test_timer_oneshot();
        logic [15:0] d;
        logic        h;
        logic [15:0] exp_rd [5];
        logic        exp_isr [5];
        exp_rd  = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        exp_isr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_write(A_TLOAD, 16'd3);
        do_read(A_TLOAD, d, h);
        n_tests++; if (d !== 16'd3) begin n_fail++; $display("FAIL tload_rb got %h exp 0003", d); end
        do_write(A_CTRL, 16'h0003);
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = A_TCOUNT;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (bus.read_data !== exp_rd[i]) begin n_fail++; $display("FAIL tcount_%0d got %h exp %h", i, bus.read_data, exp_rd[i]); end
            n_tests++; if (isr !== exp_isr[i]) begin n_fail++; $display("FAIL oneshot_isr_%0d got %b exp %b", i, isr, exp_isr[i]); end
        end
        bus.mem_addr = A_STATUS;
        tick();
        bus.mem_cmd = 2'b00;
        n_tests++; if (bus.read_data !== 16'h0001) begin n_fail++; $display("FAIL tpend_set got %h exp 0001", bus.read_data); end
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (isr) pulses++;
            end
            n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL service_no_repulse got %0d exp 0", pulses); end
        end
        do_write(A_STATUS, 16'h0001);
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL tpend_w1c got %h exp 0000", d); end
    endtask

    task automatic test_reload_w1c_race();
        logic [15:0] d;
        logic        h;
        logic [15:0] exp_rd [3];
        logic        exp_isr [3];
        int          pulses;
        exp_rd  = '{16'd2, 16'd1, 16'd2};
        exp_isr = '{1'b0, 1'b0, 1'b1};
        do_write(A_CTRL, 16'h0000);
        do_write(A_TLOAD, 16'd2);
        do_write(A_CTRL, 16'h0007);
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = A_TCOUNT;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.read_data !== exp_rd[i]) begin n_fail++; $display("FAIL reload_tcount_%0d got %h exp %h", i, bus.read_data, exp_rd[i]); end
            n_tests++; if (isr !== exp_isr[i]) begin n_fail++; $display("FAIL reload_isr_%0d got %b exp %b", i, isr, exp_isr[i]); end
        end
        // W1C lands on the same edge as the second expiry
        do_write(A_STATUS, 16'h0001);
        n_tests++; if (isr !== 1'b0) begin n_fail++; $display("FAIL race_isr_drop got %b exp 0", isr); end
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL race_tpend got %h exp 0001", d); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (isr) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL race_no_repulse got %0d exp 0", pulses); end
        do_write(A_CTRL, 16'h0002);
        do_write(A_STATUS, 16'h0001);
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL reload_clear got %h exp 0000", d); end
        n_tests++; if (isr !== 1'b0) begin n_fail++; $display("FAIL reload_clear_isr got %b exp 0", isr); end
    endtask

    task automatic test_rearm();
        logic [15:0] d;
        logic        h;
        int          pulses;
        int          first;
        do_write(A_TLOAD, 16'd2);
        do_write(A_CTRL, 16'h0003);
        pulses = 0; first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (isr) begin pulses++; if (first < 0) first = i; end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rearm1_count got %0d exp 1", pulses); end
        n_tests++; if (first !== 3) begin n_fail++; $display("FAIL rearm1_latency got %0d exp 3", first); end
        do_write(A_STATUS, 16'h0001);
        tick();
        do_write(A_TLOAD, 16'd1);
        pulses = 0; first = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (isr) begin pulses++; if (first < 0) first = i; end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rearm2_count got %0d exp 1", pulses); end
        n_tests++; if (first !== 2) begin n_fail++; $display("FAIL rearm2_latency got %0d exp 2", first); end
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL rearm2_tpend got %h exp 0001", d); end
    endtask

    task automatic test_reset_in_service();
        logic [15:0] d;
        logic        h;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (isr !== 1'b0) begin n_fail++; $display("FAIL rst_svc_isr got %b exp 0", isr); end
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rst_svc_status got %h exp 0000", d); end
        do_read(A_CTRL, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rst_svc_ctrl got %h exp 0000", d); end
        do_read(A_TCOUNT, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rst_svc_tcount got %h exp 0000", d); end
        do_read(A_TLOAD, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL rst_svc_tload got %h exp 0000", d); end
        n_tests++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_svc_leds got %h exp 00", leds); end
    endtask

    task automatic test_ext_irq();
        logic [15:0] d;
        logic        h;
        int          pulses;
        int          first;
        do_write(A_CTRL, 16'h0002);
        pulses = 0; first = -1;
`ifdef MMIO_EXT_IRQ_EN
        ext_irq = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (isr) begin pulses++; if (first < 0) first = i; end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ext_count got %0d exp 1", pulses); end
        n_tests++; if (first !== 4) begin n_fail++; $display("FAIL ext_latency got %0d exp 4", first); end
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0002) begin n_fail++; $display("FAIL ext_xpend got %h exp 0002", d); end
        do_write(A_STATUS, 16'h0002);
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL ext_w1c got %h exp 0000", d); end
        ext_irq = 1'b0;
`else
        for (int i = 1; i <= 12; i++) begin
            ext_irq = ~ext_irq;
            tick();
            if (isr) begin pulses++; if (first < 0) first = i; end
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL ext_ignored got %0d exp 0", pulses); end
        do_read(A_STATUS, d, h);
        n_tests++; if (d !== 16'h0) begin n_fail++; $display("FAIL ext_xpend_zero got %h exp 0000", d); end
        ext_irq = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_led();
        test_timer_oneshot();
        test_reload_w1c_race();
        test_rearm();
        test_reset_in_service();
        test_ext_irq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
